// File: rtl/tri_bus_arbiter_pkg.sv
// Shared definitions for the tri-state bus arbiter: FSM encodings, requester
// sizing, parameter legal ranges and small helpers.
package tri_bus_arbiter_pkg;

  localparam int N      = 4;
  localparam int IDX_W  = 2;
  localparam int HOLD_W = 4;
  localparam int TURN_W = 3;

  localparam int HOLD_MAX_MIN = 1;
  localparam int HOLD_MAX_LIM = 15;
  localparam int TURN_CYC_MIN = 1;
  localparam int TURN_CYC_LIM = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    TURN  = 2'b10
  } state_t;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Round-robin winner selection: first set request scanning from last+1
// upward, wrapping, with the previous winner considered last.
module rr_pick
  import tri_bus_arbiter_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] win,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan farthest-first so the nearest set bit after last overwrites the rest.
  always_comb begin
    win  = last;
    cand = '0;
    any  = |req;
    for (int k = N; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (req[cand]) win = cand;
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus: drives the 4:1 mux select and
// the output-stage enable, inserting a dead turnaround between owners.
module tri_bus_arbiter
  import tri_bus_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int TURN_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] sel,
  output logic             bus_en,
  output logic             busy
);

  localparam logic [HOLD_W-1:0] HOLD_LIM =
    HOLD_W'(clamp_int(HOLD_MAX, HOLD_MAX_MIN, HOLD_MAX_LIM));
  localparam logic [TURN_W-1:0] TURN_LIM =
    TURN_W'(clamp_int(TURN_CYC, TURN_CYC_MIN, TURN_CYC_LIM));

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic [N-1:0]       gnt_d;
  logic [IDX_W-1:0]   sel_d;
  logic               bus_en_d, busy_d;
  logic [IDX_W-1:0]   win;
  logic               any;
  logic               owner_req, others, start_grant;

  rr_pick u_pick (
    .req  (req),
    .last (last_q),
    .win  (win),
    .any  (any)
  );

  assign owner_req = req[last_q];
  assign others    = |(req & ~to_onehot(last_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N - 1);
      hold_q  <= '0;
      turn_q  <= '0;
      gnt     <= '0;
      sel     <= '0;
      bus_en  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      bus_en  <= bus_en_d;
      busy    <= busy_d;
    end
  end

  // last_q doubles as the current owner while in GRANT; sel is only ever
  // reloaded when a new grant starts, so it cannot move under an active driver.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    hold_d      = hold_q;
    turn_d      = turn_q;
    gnt_d       = gnt;
    sel_d       = sel;
    bus_en_d    = bus_en;
    busy_d      = busy;
    start_grant = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d    = '0;
        bus_en_d = 1'b0;
        busy_d   = 1'b0;
        if (any) start_grant = 1'b1;
      end

      GRANT: begin
        if (owner_req && (!others || (hold_q < HOLD_LIM))) begin
          if (hold_q < HOLD_LIM) hold_d = hold_q + HOLD_W'(1);
        end else begin
          state_d  = TURN;
          turn_d   = TURN_W'(1);
          hold_d   = '0;
          gnt_d    = '0;
          bus_en_d = 1'b0;
          busy_d   = 1'b1;
        end
      end

      TURN: begin
        gnt_d    = '0;
        bus_en_d = 1'b0;
        if (turn_q >= TURN_LIM) begin
          if (any) begin
            start_grant = 1'b1;
          end else begin
            state_d = IDLE;
            turn_d  = '0;
            busy_d  = 1'b0;
          end
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        hold_d   = '0;
        turn_d   = '0;
        gnt_d    = '0;
        bus_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    if (start_grant) begin
      state_d  = GRANT;
      last_d   = win;
      hold_d   = HOLD_W'(1);
      turn_d   = '0;
      gnt_d    = to_onehot(win);
      sel_d    = win;
      bus_en_d = 1'b1;
      busy_d   = 1'b1;
    end
  end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench for tri_bus_arbiter: directed vectors with hand-computed
// responses, exhaustive rr_pick table, bus invariants and a starvation bound.
module tb_tri_bus_arbiter;
  import tri_bus_arbiter_pkg::*;

  localparam int HOLD  = 4;
  localparam int TURN1 = 1;
  localparam int TURN3 = 3;
  localparam int BOUND = 3 * (HOLD + TURN1);

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       use3;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt, gnt3;
  logic [1:0] sel, sel3;
  logic       bus_en, bus_en3, busy, busy3;

  logic [6:0] pk_idx = 7'd0;
  logic [3:0] pk_req;
  logic [1:0] pk_last, pk_win;
  logic       pk_any;

  exp_t       sb[$];
  exp_t       cur;
  int         tests_run = 0;
  int         tests_failed = 0;
  logic       rand_phase = 1'b0;
  logic [3:0] prev_gnt = 4'b0000;
  logic [1:0] prev_sel = 2'b00;
  logic       prev_en = 1'b0;
  logic [3:0] drv_prev = 4'b0000;
  int         wait_cnt[4];
  logic       inv_ok;

  always #5 clk = ~clk;

  tri_bus_arbiter #(.HOLD_MAX(HOLD), .TURN_CYC(TURN1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .sel(sel), .bus_en(bus_en), .busy(busy)
  );

  tri_bus_arbiter #(.HOLD_MAX(HOLD), .TURN_CYC(TURN3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt3), .sel(sel3), .bus_en(bus_en3), .busy(busy3)
  );

  assign pk_req  = pk_idx[3:0];
  assign pk_last = pk_idx[5:4];

  rr_pick u_pick (.req(pk_req), .last(pk_last), .win(pk_win), .any(pk_any));

  // Reference pick: smallest forward distance from last+1.
  function automatic logic [1:0] ref_pick(input logic [3:0] r, input logic [1:0] l);
    int         best;
    int         d;
    logic [1:0] w;
    best = 4;
    w    = 2'b00;
    for (int i = 0; i < 4; i++) begin
      d = (i - int'(l) + 7) % 4;
      if (r[i] && d < best) begin
        best = d;
        w    = 2'(i);
      end
    end
    return w;
  endfunction

  task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic [3:0] r, input logic [3:0] eg,
                               input logic [1:0] es, input logic ee, input logic eb,
                               input logic u3, input string nm);
    exp_t item;
    @(negedge clk);
    rst_n     = rn;
    req       = r;
    item.gnt  = eg;
    item.sel  = es;
    item.en   = ee;
    item.busy = eb;
    item.use3 = u3;
    item.name = nm;
    sb.push_back(item);
  endtask

  // Single monitor: scoreboard pops, rr_pick table, invariants, starvation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      if (cur.use3)
        checkOutput(cur.name, {gnt3, sel3, bus_en3, busy3}, {cur.gnt, cur.sel, cur.en, cur.busy});
      else
        checkOutput(cur.name, {gnt, sel, bus_en, busy}, {cur.gnt, cur.sel, cur.en, cur.busy});
    end

    if (pk_idx < 7'd64) begin
      checkOutput("rr_pick", {5'd0, pk_any, pk_any ? pk_win : 2'b00},
                  {5'd0, |pk_req, ref_pick(pk_req, pk_last)});
      pk_idx = pk_idx + 7'd1;
    end

    inv_ok = ((gnt & (gnt - 4'd1)) == 4'd0) &&
             (bus_en == (gnt != 4'd0)) &&
             ((gnt == 4'd0) || (gnt == (4'b0001 << sel))) &&
             !(prev_en && bus_en && ((sel != prev_sel) || (gnt != prev_gnt)));
    checkOutput("invariant", {7'd0, inv_ok}, 8'd1);

    for (int i = 0; i < 4; i++) begin
      if (!rand_phase) begin
        wait_cnt[i] = 0;
      end else if (gnt[i]) begin
        if (!prev_gnt[i]) checkOutput("starve_wait", 8'(wait_cnt[i] > BOUND), 8'd0);
        wait_cnt[i] = 0;
      end else if (req[i]) begin
        wait_cnt[i]++;
        if (wait_cnt[i] == BOUND + 1) checkOutput("starve_bound", 8'(wait_cnt[i]), 8'(BOUND));
      end else begin
        wait_cnt[i] = 0;
      end
    end

    prev_gnt = gnt;
    prev_sel = sel;
    prev_en  = bus_en;
  end

  initial begin
    // Reset, lone requester, saturated hold then forced release.
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, "reset_state");
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 1, "reset_state_t3");
    applyStimulus(1, 4'b0001, 4'b0001, 2'd0, 1, 1, 0, "first_grant");
    repeat (20) applyStimulus(1, 4'b0001, 4'b0001, 2'd0, 1, 1, 0, "lone_hold");
    applyStimulus(1, 4'b0011, 4'b0000, 2'd0, 0, 1, 0, "saturated_release");
    applyStimulus(1, 4'b0011, 4'b0010, 2'd1, 1, 1, 0, "rr_after_release");

    // All four requesting: 4-cycle grants separated by 1 turnaround cycle.
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, "reset2");
    for (int k = 0; k < 5; k++) begin
      repeat (HOLD) applyStimulus(1, 4'b1111, to_onehot(2'(k)), 2'(k), 1, 1, 0, "rr_grant");
      if (k < 4) applyStimulus(1, 4'b1111, 4'b0000, 2'(k), 0, 1, 0, "rr_turn");
    end

    // Owner 2 drops early; 3 then 0 follow.
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, "reset3");
    applyStimulus(1, 4'b0100, 4'b0100, 2'd2, 1, 1, 0, "owner2_grant");
    applyStimulus(1, 4'b1100, 4'b0100, 2'd2, 1, 1, 0, "owner2_hold");
    applyStimulus(1, 4'b1001, 4'b0000, 2'd2, 0, 1, 0, "owner2_drop_turn");
    applyStimulus(1, 4'b1001, 4'b1000, 2'd3, 1, 1, 0, "owner3_grant");
    repeat (3) applyStimulus(1, 4'b1001, 4'b1000, 2'd3, 1, 1, 0, "owner3_hold");
    applyStimulus(1, 4'b1001, 4'b0000, 2'd3, 0, 1, 0, "owner3_forced_turn");
    applyStimulus(1, 4'b1001, 4'b0001, 2'd0, 1, 1, 0, "owner0_next");

    // Reset in the middle of a grant, pointer restarts at 3.
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, "reset4");
    applyStimulus(1, 4'b0100, 4'b0100, 2'd2, 1, 1, 0, "pre_reset_grant");
    applyStimulus(0, 4'b0100, 4'b0000, 2'd0, 0, 0, 0, "reset_mid_grant");
    applyStimulus(1, 4'b0110, 4'b0010, 2'd1, 1, 1, 0, "pointer_reset");
    applyStimulus(1, 4'b0000, 4'b0000, 2'd1, 0, 1, 0, "drop_to_turn");
    applyStimulus(1, 4'b0000, 4'b0000, 2'd1, 0, 0, 0, "turn_to_idle");

    // Three-cycle turnaround, request appears mid-turn.
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 1, "t3_reset");
    applyStimulus(1, 4'b0001, 4'b0001, 2'd0, 1, 1, 1, "t3_grant0");
    applyStimulus(1, 4'b0000, 4'b0000, 2'd0, 0, 1, 1, "t3_turn1");
    applyStimulus(1, 4'b0000, 4'b0000, 2'd0, 0, 1, 1, "t3_turn2");
    applyStimulus(1, 4'b0010, 4'b0000, 2'd0, 0, 1, 1, "t3_turn3");
    applyStimulus(1, 4'b0010, 4'b0010, 2'd1, 1, 1, 1, "t3_grant1");

    // Random sticky requests: hold until granted, withdraw once the grant ends.
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, "reset_rand");
    @(negedge clk);
    rst_n      = 1'b1;
    drv_prev   = 4'b0000;
    rand_phase = 1'b1;
    repeat (10000) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (drv_prev[i] && !gnt[i])
          req[i] = 1'b0;
        else if (!req[i] && $urandom_range(7) == 0)
          req[i] = 1'b1;
        else if (gnt[i] && $urandom_range(3) == 0)
          req[i] = 1'b0;
      end
      drv_prev = gnt;
    end
    rand_phase = 1'b0;
    req        = 4'b0000;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the 4:1 tri-state-buffer mux datapath.
- Shares one tri-state bus among 4 requesters and drives the mux select pair (sel[1]→s1, sel[0]→s0).
- Gates the output-stage tri-state enable (bus_en).
- Guarantees a dead (all-drivers-off) turnaround between owners, so two buffers never drive the shared wire in the same cycle.

Parameters:
HOLD_MAX, 4, max consecutive grant cycles while another requester is pending; legal range 1..15.
TURN_CYC, 1, bus-idle turnaround cycles between owners; legal range 1..7.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset; sampled on rising clk edge.
req  input  4  request per requester; bit i = mux input i (0=a, 1=b, 2=c, 3=d).
gnt  output  4  one-hot grant, or 0 when no owner; registered.
sel  output  2  mux select {s1,s0} of current/last owner; registered.
bus_en  output  1  enable for the output tri-state stage; high only in GRANT; registered.
busy  output  1  high in GRANT or TURN; registered.

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE; gnt=0, sel=0, bus_en=0, busy=0.
  - Priority pointer last=3, so requester 0 has top priority first.
  - Hold and turn counters = 0.
  - Applies mid-grant too: bus released on the next cycle, no turnaround.
- States:
  - IDLE: bus undriven.
  - GRANT: one owner drives.
  - TURN: all gnt=0, bus_en=0, sel held at the previous owner.
- Round-robin pick: the first set req bit scanning (last+1), (last+2), (last+3), last, mod 4.
- IDLE→GRANT: at any edge with req≠0.
  - gnt/sel/bus_en valid the cycle after req is sampled (latency 1).
  - last←winner; hold counter←1.
- GRANT, owner's req=1, no other req: stay; hold counter saturates at HOLD_MAX. A lone requester keeps the bus indefinitely.
- GRANT, owner's req=1, another req pending, hold counter<HOLD_MAX: stay; counter+1.
- GRANT, owner's req=1, another req pending, hold counter=HOLD_MAX: →TURN (forced release).
- GRANT, owner's req=0: →TURN.
- TURN: count TURN_CYC cycles. At the end:
  - req≠0 → GRANT to the round-robin winner, which may be the previous owner if it is the only requester.
  - req=0 → IDLE.
- Requests arriving during TURN are evaluated only at its final edge. The winner is picked at that edge from the req then present.
- Simultaneous requests in IDLE: round-robin from last+1.
- sel always equals the binary index of the set gnt bit whenever gnt≠0. sel changes only on the edge entering GRANT, never while bus_en=1.
- Invariants:
  - gnt is one-hot or zero.
  - bus_en=1 ⇔ gnt≠0.
  - At least TURN_CYC cycles with bus_en=0 between any two GRANT periods.
- X/illegal state encoding → IDLE on the next edge.

Decomposition:
- Shared include/package holds:
  - State encodings: IDLE=2'b00, GRANT=2'b01, TURN=2'b10.
  - Requester count N=4 and its index width 2.
  - HOLD_MAX/TURN_CYC legal-range constants.
- One combinational sub-module, rr_pick:
  - Inputs: req[3:0], last[1:0].
  - Outputs: win[1:0], any.
  - Kept separate so the bench can check it exhaustively (64 cases).
- The FSM, counters and output registers stay in tri_bus_arbiter.

Test Plan:
- Reset then req=4'b0001 from cycle 2 → gnt=0001, sel=00, bus_en=1 at cycle 3; holds while req0 stays high alone for 20 cycles.
- req=4'b1111 held, HOLD_MAX=4, TURN_CYC=1 → grant order 0,1,2,3,0. Each grant lasts 4 cycles, followed by 1 cycle with gnt=0, bus_en=0, sel unchanged.
- Owner 2 drops req after 2 cycles while req3=1 → TURN for 1 cycle, then gnt=1000, sel=11. Owner 0 pending behind 3 gets the next slot.
- TURN_CYC=3, req1 asserted in the 2nd turn cycle, previous owner 0 gone → bus_en=0 for exactly 3 cycles, then gnt=0010, sel=01.
- rst_n=0 during GRANT with gnt=0100 → next cycle gnt=0, bus_en=0, busy=0. After release with req=0110, first grant goes to 1 (pointer reset to 3).
- Continuous assertion checks: gnt one-hot/zero, bus_en⇔gnt≠0, no sel change while bus_en=1. Random req for 10k cycles; no requester is starved for more than 3·(HOLD_MAX+TURN_CYC) cycles.
